pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//   Parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) with depth STAGES.
//   Carries a data payload and a control bundle, with stall (hold) and flush (bubble insertion).
//   Adds a per-stage valid bit and a saturating bubble counter for performance debug.
//   Sits between two processor stages.
//   Feeds the forwarding and hazard units through out_valid/out_ctrl.
// PARAMETERS
//   DATA_W     48   payload width (ALU result, Rs data, Rd data, Rd index, ...)
//   CTRL_W     15   control bundle width (memRead, memWrite, regWrite, push/pop, ...)
//   CTRL_RST   0    control value loaded on reset and on flush (the bubble/NOP encoding)
//   STAGES     1    number of chained register slots (1..4); total latency = STAGES cycles
//   CNT_W      16   bubble counter width
// PORTS
//   clk        in   1       single clock; all state updates on posedge only
//   rst_n      in   1       asynchronous active-low reset
//   stall      in   1       hold all slots unchanged this cycle
//   flush      in   1       replace the contents of every slot with a bubble this cycle
//   in_valid   in   1       in_data/in_ctrl hold a real instruction
//   in_data    in   DATA_W  payload from the upstream stage
//   in_ctrl    in   CTRL_W  control from the upstream stage
//   out_valid  out  1       last slot holds a real instruction
//   out_data   out  DATA_W  payload of the last slot
//   out_ctrl   out  CTRL_W  control of the last slot; forced to CTRL_RST when out_valid=0
//   bubble_cnt out  CNT_W   count of cycles in which out_valid=0 after reset; saturates
// BEHAVIOUR
//   - Reset (rst_n=0, asynchronous):
//       all slots: valid=0, data=0, ctrl=CTRL_RST.
//       bubble_cnt=0; out_* reflect the cleared slot immediately.
//       After reset the forwarding unit never sees stale X values.
//   - Normal cycle (stall=0, flush=0):
//       slot[0] <= {in_valid, in_data, in_ctrl}; slot[i] <= slot[i-1] for i>0.
//   - Bubble values when in_valid=0:
//       slot[0].ctrl is loaded with CTRL_RST, not in_ctrl.
//       This prevents spurious memWrite/regWrite. Data is still captured (don't-care).
//   - stall=1, flush=0: every slot keeps its value; the outputs are unchanged.
//   - flush=1 (with or without stall): every slot becomes valid=0, ctrl=CTRL_RST.
//       Data is unchanged. Flush wins over stall.
//   - out_* are driven combinationally from slot[STAGES-1]; no extra output register.
//       out_ctrl = out_valid ? slot.ctrl : CTRL_RST.
//   - Latency: an input accepted at edge N appears at out_* after edge N+STAGES-1.
//       This counts only non-stalled edges.
//       Examples: STAGES=1 -> visible right after the capturing edge; STAGES=3 -> 2 further unstalled edges.
//   - bubble_cnt increments on each posedge where, before the edge, out_valid=0.
//       It holds at 2^CNT_W-1 (saturation); it counts during stall as well.
//   - Reset mid-operation: in-flight slots are lost. The first valid output is the first in_valid sampled after release.
//   - STAGES outside 1..4: elaboration error via generate-time check.
// TESTING
//   1. Reset: rst_n=0 mid-cycle -> out_valid=0, out_ctrl=CTRL_RST, out_data=0, bubble_cnt=0 without a clock edge.
//   2. Pass-through, STAGES=1: in_valid=1, data=48'h1234, ctrl=15'h0800 -> next posedge out_valid=1, data 48'h1234, ctrl 15'h0800.
//   3. Stall: load 48'hAAAA, then stall=1 for 3 cycles with data=48'hBBBB -> out_data stays 48'hAAAA. Release -> 48'hBBBB.
//   4. Flush vs stall: STAGES=3, 3 valid entries, then stall=1 and flush=1 together.
//        -> next edge out_valid=0, out_ctrl=0; then 2 more edges of valid input -> first new entry appears on the 3rd edge.
//   5. Bubble gating: in_valid=0 with in_ctrl=15'h7FFF -> out_ctrl=CTRL_RST; bubble_cnt rises by 1 per bubble cycle.
//   6. Saturation: CNT_W=4, hold in_valid=0 for 20 cycles -> bubble_cnt stops at 4'hF; reset returns it to 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) made of
//   STAGES chained slots. Each slot carries a valid bit, a data payload and a
//   control bundle. Supports stall (hold every slot) and flush (turn every
//   slot into a bubble). A saturating counter tracks cycles in which the
//   output slot held a bubble, for performance debug.
//
// Parameters
//   DATA_W    payload width
//   CTRL_W    control bundle width
//   CTRL_RST  control encoding of a bubble (loaded on reset, flush, in_valid=0)
//   STAGES    number of chained slots, 1..4 (latency in unstalled cycles)
//   CNT_W     bubble counter width
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   stall       in   hold all slots this cycle
//   flush       in   replace every slot with a bubble (wins over stall)
//   in_valid    in   upstream holds a real instruction
//   in_data     in   upstream payload
//   in_ctrl     in   upstream control
//   out_valid   out  last slot holds a real instruction
//   out_data    out  payload of the last slot
//   out_ctrl    out  control of the last slot, CTRL_RST when out_valid=0
//   bubble_cnt  out  saturating count of edges seen with out_valid=0
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int                 DATA_W   = 48,
  parameter int                 CTRL_W   = 15,
  parameter logic [CTRL_W-1:0]  CTRL_RST = '0,
  parameter int                 STAGES   = 1,
  parameter int                 CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);

  if (STAGES < 1 || STAGES > 4) begin : g_stages_check
    $error("pipe_stage_reg: STAGES must be in 1..4");
  end

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) begin
      return c;
    end
    return c + 1'b1;
  endfunction

  // Slot storage: index 0 is fed from upstream, index STAGES-1 drives out_*.
  logic              r_vld_p  [STAGES];
  logic [DATA_W-1:0] r_data_p [STAGES];
  logic [CTRL_W-1:0] r_ctrl_p [STAGES];
  logic [CNT_W-1:0]  r_bub_cnt;

  // Bubbles never carry upstream control, so a dropped instruction cannot
  // leak memWrite/regWrite into later stages.
  logic [CTRL_W-1:0] w_in_ctrl;
  assign w_in_ctrl = in_valid ? in_ctrl : CTRL_RST;

  // ---- slot chain ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_vld_p[i]  <= 1'b0;
        r_data_p[i] <= '0;
        r_ctrl_p[i] <= CTRL_RST;
      end
    end else if (flush) begin
      // Payload is left as-is; only valid and control define a bubble.
      for (int i = 0; i < STAGES; i++) begin
        r_vld_p[i]  <= 1'b0;
        r_ctrl_p[i] <= CTRL_RST;
      end
    end else if (!stall) begin
      r_vld_p[0]  <= in_valid;
      r_data_p[0] <= in_data;
      r_ctrl_p[0] <= w_in_ctrl;
      for (int i = 1; i < STAGES; i++) begin
        r_vld_p[i]  <= r_vld_p[i-1];
        r_data_p[i] <= r_data_p[i-1];
        r_ctrl_p[i] <= r_ctrl_p[i-1];
      end
    end
  end

  // ---- output slot (combinational, no extra register) ----
  assign out_valid = r_vld_p[STAGES-1];
  assign out_data  = r_data_p[STAGES-1];
  assign out_ctrl  = r_vld_p[STAGES-1] ? r_ctrl_p[STAGES-1] : CTRL_RST;

  // ---- bubble counter ----
  // Looks at out_valid before the edge and keeps counting through stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bub_cnt <= '0;
    end else if (!out_valid) begin
      r_bub_cnt <= sat_inc(r_bub_cnt);
    end
  end

  assign bubble_cnt = r_bub_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances with different depth, counter
// width and bubble encoding share one stimulus stream and are checked each
// cycle against a queue-based reference model, plus literal expectations.
module tb_pipe_stage_reg;

  localparam int DW = 48;
  localparam int CW = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic          o_vld  [3];
  logic [DW-1:0] o_data [3];
  logic [CW-1:0] o_ctrl [3];
  logic [3:0]    bc0;
  logic [15:0]   bc1;
  logic [15:0]   bc2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST(15'h0000), .STAGES(1), .CNT_W(4)) u_s1 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(o_vld[0]), .out_data(o_data[0]), .out_ctrl(o_ctrl[0]), .bubble_cnt(bc0));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST(15'h0000), .STAGES(3), .CNT_W(16)) u_s3 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(o_vld[1]), .out_data(o_data[1]), .out_ctrl(o_ctrl[1]), .bubble_cnt(bc1));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST(15'h02A5), .STAGES(4), .CNT_W(16)) u_s4 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(o_vld[2]), .out_data(o_data[2]), .out_ctrl(o_ctrl[2]), .bubble_cnt(bc2));

  // Per-instance configuration.
  function automatic int st(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 4;
  endfunction

  function automatic logic [CW-1:0] crst(input int k);
    return (k == 2) ? 15'h02A5 : 15'h0000;
  endfunction

  function automatic int cmax(input int k);
    return (k == 0) ? 15 : 65535;
  endfunction

  function automatic logic [63:0] got_cnt(input int k);
    case (k)
      0:       return 64'(bc0);
      1:       return 64'(bc1);
      default: return 64'(bc2);
    endcase
  endfunction

  // Reference model: each instance is a queue of entries, front = newest.
  // An entry reaches the output once it has been pushed STAGES-1 more times.
  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t mq [3][$];
  int   m_cnt [3];
  ent_t me;

  function automatic ent_t mk(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c);
    ent_t e;
    e.v = v;
    e.d = d;
    e.c = c;
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        mq[k].delete();
        for (int i = 0; i < st(k); i++) mq[k].push_back(mk(1'b0, '0, crst(k)));
        m_cnt[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (!mq[k][st(k)-1].v && m_cnt[k] < cmax(k)) m_cnt[k] = m_cnt[k] + 1;
        if (flush) begin
          for (int i = 0; i < st(k); i++) begin
            me = mq[k][i];
            me.v = 1'b0;
            me.c = crst(k);
            mq[k][i] = me;
          end
        end else if (!stall) begin
          mq[k].push_front(mk(in_valid, in_data, in_valid ? in_ctrl : crst(k)));
          void'(mq[k].pop_back());
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic compare();
    ent_t h;
    for (int k = 0; k < 3; k++) begin
      h = mq[k][st(k)-1];
      chk($sformatf("u%0d out_valid", k), 64'(o_vld[k]),  64'(h.v));
      chk($sformatf("u%0d out_data", k),  64'(o_data[k]), 64'(h.d));
      chk($sformatf("u%0d out_ctrl", k),  64'(o_ctrl[k]), 64'(h.v ? h.c : crst(k)));
      chk($sformatf("u%0d bubble_cnt", k), got_cnt(k),    64'(m_cnt[k]));
    end
  endtask

  // Inputs change at negedge; the following negedge compares the result.
  task automatic step(input logic s, input logic f, input logic v,
                      input logic [DW-1:0] d, input logic [CW-1:0] c);
    stall    = s;
    flush    = f;
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
    @(negedge clk);
    compare();
  endtask

  // Asynchronous reset pulse between edges; called right at a negedge.
  task automatic rst_pulse();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d async rst valid", k), 64'(o_vld[k]),  64'h0);
      chk($sformatf("u%0d async rst data", k),  64'(o_data[k]), 64'h0);
      chk($sformatf("u%0d async rst ctrl", k),  64'(o_ctrl[k]), 64'(crst(k)));
      chk($sformatf("u%0d async rst cnt", k),   got_cnt(k),     64'h0);
    end
    compare();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] r64;
    int          base;
    rst_n    = 1'b1;
    stall    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_ctrl  = '0;

    // Reset asserted mid-cycle before any clock edge.
    rst_pulse();
    rst_n = 1'b0;
    @(negedge clk);
    compare();
    rst_n = 1'b1;

    // Pass-through on the single-slot instance.
    step(1'b0, 1'b0, 1'b1, 48'h1234, 15'h0800);
    chk("s1 pass valid", 64'(o_vld[0]),  64'h1);
    chk("s1 pass data",  64'(o_data[0]), 64'h1234);
    chk("s1 pass ctrl",  64'(o_ctrl[0]), 64'h0800);

    // Stall holds the slot contents.
    step(1'b0, 1'b0, 1'b1, 48'hAAAA, 15'h0011);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 48'hBBBB, 15'h0022);
      chk("s1 stall hold", 64'(o_data[0]), 64'hAAAA);
    end
    step(1'b0, 1'b0, 1'b1, 48'hBBBB, 15'h0022);
    chk("s1 stall release", 64'(o_data[0]), 64'hBBBB);

    // Flush together with stall on the 3-slot instance.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 48'h100 + 48'(i), 15'(i + 1));
    chk("s3 latency data",  64'(o_data[1]), 64'h100);
    chk("s3 latency valid", 64'(o_vld[1]),  64'h1);
    step(1'b1, 1'b1, 1'b1, 48'h999, 15'h0003);
    chk("s3 flush valid", 64'(o_vld[1]),  64'h0);
    chk("s3 flush ctrl",  64'(o_ctrl[1]), 64'h0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b1, 48'h200 + 48'(i), 15'h0005);
      chk("s3 refill bubble", 64'(o_vld[1]), 64'h0);
    end
    step(1'b0, 1'b0, 1'b1, 48'h202, 15'h0005);
    chk("s3 refill valid", 64'(o_vld[1]),  64'h1);
    chk("s3 refill data",  64'(o_data[1]), 64'h200);

    // Bubbles must not carry upstream control.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 48'h5555, 15'h7FFF);
      chk("s1 bubble ctrl", 64'(o_ctrl[0]), 64'h0);
    end
    chk("s4 bubble ctrl",  64'(o_ctrl[2]), 64'h02A5);
    chk("s4 bubble valid", 64'(o_vld[2]),  64'h0);
    base = m_cnt[1];
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 48'h5555, 15'h7FFF);
    chk("s3 bubble rise", got_cnt(1), 64'(base + 3));

    // Saturation of the 4-bit counter, then reset clears it.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 48'h0, 15'h7FFF);
    chk("s1 cnt saturate", got_cnt(0), 64'hF);
    rst_pulse();
    chk("s1 cnt after rst", got_cnt(0), 64'h0);

    // Randomised traffic with occasional mid-operation resets.
    for (int n = 0; n < 300; n++) begin
      if (n % 97 == 50) rst_pulse();
      r64 = {$urandom(), $urandom()};
      step(($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) < 7), r64[DW-1:0],
           ($urandom_range(0, 7) == 0) ? 15'h7FFF : 15'($urandom()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
